instruction_memory_pipelined: RTL and testbench

Parametrised, handshaked instruction memory that replaces the single-cycle, fixed-size instruction store in the instruction-fetch stage. It accepts word-addressed fetch requests over a valid/ready interface and returns instructions after a configurable read latency. It buffers responses under back-pressure and supports pipeline flush on branch redirect. It also has a program-load write port, so test programs no longer need to be hard-coded.

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/sync_fifo_fwft.sv | 80 ++++++++
 rtl/instruction_memory_pipelined.sv | 155 +++++++++++++++
 tb/tb_instruction_memory_pipelined.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared ISA definitions for the fetch path: instruction type codes, function
// codes, architectural register names, instruction field widths and the
// default NOP word returned on a faulting fetch.
// No ports (package).
// -----------------------------------------------------------------------------
package isa_pkg;

   // Instruction field widths
   localparam int FUNCT_W = 5;
   localparam int REG_W   = 5;
   localparam int IMM_W   = 14;
   localparam int JIMM_W  = 24;   // signed jump immediate
   localparam int TYPE_W  = 2;
   localparam int STOP_W  = 1;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [TYPE_W-1:0] {
      TYPE_R = 2'd0,
      TYPE_I = 2'd1,
      TYPE_J = 2'd2,
      TYPE_S = 2'd3
   } instr_type_e;

   typedef enum logic [FUNCT_W-1:0] {
      FN_NOP = 5'd0,
      FN_ADD = 5'd1,
      FN_SUB = 5'd2,
      FN_AND = 5'd3,
      FN_OR  = 5'd4,
      FN_XOR = 5'd5,
      FN_SLL = 5'd6,
      FN_SRL = 5'd7,
      FN_LD  = 5'd8,
      FN_ST  = 5'd9,
      FN_BEQ = 5'd10,
      FN_JMP = 5'd11
   } funct_e;

   typedef enum logic [REG_W-1:0] {
      REG_ZERO = 5'd0,
      REG_RA   = 5'd1,
      REG_SP   = 5'd2,
      REG_GP   = 5'd3,
      REG_T0   = 5'd4,
      REG_T1   = 5'd5,
      REG_A0   = 5'd6,
      REG_A1   = 5'd7
   } reg_name_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_en pops it. DEPTH need not be a power of
// two. clear empties the FIFO synchronously and wins over push/pop.
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   clear                synchronous empty
//   wr_en, wr_data, full push side
//   rd_en, rd_data, empty pop side (head is rd_data)
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Pointers wrap explicitly because DEPTH may not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop     = rd_en && !empty;
   assign push    = wr_en && (!full || pop);
   assign rd_data = store[rd_ptr];

   always_ff @(posedge clock) begin
      if (push)
         store[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(wr_en && full && !rd_en));

endmodule

// File: rtl/instruction_memory_pipelined.sv
// -----------------------------------------------------------------------------
// instruction_memory_pipelined
// Handshaked instruction memory for the fetch stage. Word-addressed requests
// are accepted over valid/ready, read from a sync RAM at accept, carried
// through READ_LATENCY-1 further register stages and queued in an output
// FWFT FIFO. Out-of-range fetches return NOP_WORD with resp_fault set.
// flush drops everything in flight; load_* writes program words.
// Ports:
//   clock, reset_n                   clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr     fetch request
//   resp_valid/resp_ready            response handshake
//   resp_instr/resp_addr/resp_fault  response payload (zero while not valid)
//   flush                            discard in-flight and buffered responses
//   load_en/load_addr/load_data      program-load write port
//   busy                             any request outstanding
// -----------------------------------------------------------------------------
module instruction_memory_pipelined
   import isa_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_instr,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic                  resp_fault,
   input  logic                  flush,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  busy
);

   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OUT_W      = $clog2(READ_LATENCY + 2);
   localparam int FIFO_DEPTH = READ_LATENCY + 1;
   localparam int ENTRY_W    = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
   localparam logic [OUT_W-1:0]      OUT_MAX = OUT_W'(READ_LATENCY + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [OUT_W-1:0]        outstanding;
   logic                    accept;
   logic                    resp_hs;
   logic                    req_in_range;
   logic                    load_in_range;

   logic [READ_LATENCY-1:0] vld_p;
   logic [DATA_WIDTH-1:0]   instr_p [READ_LATENCY];
   logic [ADDR_WIDTH-1:0]   addr_p  [READ_LATENCY];
   logic                    fault_p [READ_LATENCY];

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [ENTRY_W-1:0]      fifo_head;
   logic [DATA_WIDTH-1:0]   head_instr;
   logic [ADDR_WIDTH-1:0]   head_addr;
   logic                    head_fault;

   assign req_in_range  = (req_addr < DEPTH_A);
   assign load_in_range = (load_addr < DEPTH_A);

   // The outstanding cap equals the FIFO depth, so the FIFO can absorb every
   // in-flight read even if the consumer stalls.
   assign req_ready = !flush && !load_en && (outstanding < OUT_MAX);
   assign accept    = req_valid && req_ready;
   assign resp_hs   = resp_valid && resp_ready;
   assign busy      = (outstanding != '0);

   always_ff @(posedge clock) begin
      if (load_en && load_in_range)
         mem[load_addr[IDX_W-1:0]] <= load_data;
   end

   // ---- stage p0: RAM read at accept; later stages shift unconditionally ----
   always_ff @(posedge clock) begin
      if (accept) begin
         instr_p[0] <= req_in_range ? mem[req_addr[IDX_W-1:0]] : NOP_WORD;
         addr_p[0]  <= req_addr;
         fault_p[0] <= !req_in_range;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         instr_p[i] <= instr_p[i-1];
         addr_p[i]  <= addr_p[i-1];
         fault_p[i] <= fault_p[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p <= '0;
      end else if (flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i < READ_LATENCY; i++)
            vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
      end else if (flush) begin
         outstanding <= '0;
      end else begin
         case ({accept, resp_hs})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // ---- last stage -> output FIFO ----
   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_resp_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (flush),
      .wr_en   (vld_p[READ_LATENCY-1]),
      .wr_data ({instr_p[READ_LATENCY-1], addr_p[READ_LATENCY-1], fault_p[READ_LATENCY-1]}),
      .full    (fifo_full),
      .rd_en   (resp_hs),
      .rd_data (fifo_head),
      .empty   (fifo_empty)
   );

   assign {head_instr, head_addr, head_fault} = fifo_head;

   // Payload is forced to zero while no response is present so reset and idle
   // values are defined even though the FIFO storage itself is not reset.
   assign resp_valid = !fifo_empty;
   assign resp_instr = resp_valid ? head_instr : '0;
   assign resp_addr  = resp_valid ? head_addr  : '0;
   assign resp_fault = resp_valid && head_fault;

   // FIFO entries are a subset of outstanding requests, so a full FIFO means
   // the outstanding count sits at its cap.
   a_full_implies_cap: assert property (@(posedge clock) disable iff (!reset_n)
      fifo_full |-> (outstanding == OUT_MAX));

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_pipelined
// Drives directed and randomized traffic into instruction_memory_pipelined
// (READ_LATENCY=2, DEPTH=256) and compares every cycle against a transaction
// model: a word array for memory and a queue of expected responses, each
// tagged with the earliest edge at which it may appear.
// -----------------------------------------------------------------------------
module tb_instruction_memory_pipelined;

   localparam int          RL    = 2;
   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [31:0] resp_addr;
   logic        resp_fault;
   logic        flush;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        busy;

   instruction_memory_pipelined #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .DEPTH        (DEPTH),
      .READ_LATENCY (RL),
      .NOP_WORD     (NOP)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_addr  (resp_addr),
      .resp_fault (resp_fault),
      .flush      (flush),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        fault;
      int          t;      // first edge count at which the response may show
   } exp_t;

   exp_t        q[$];
   logic [31:0] mmem [DEPTH];
   int          edges  = 0;
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
   endtask

   // One clock cycle: apply inputs, compare outputs with the model, advance model.
   task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic fl, input logic le, input logic [31:0] la,
                       input logic [31:0] ld);
      exp_t e;
      logic m_valid, m_ready, hs, acc;
      @(negedge clock);
      req_valid  = rv;
      req_addr   = ra;
      resp_ready = rr;
      flush      = fl;
      load_en    = le;
      load_addr  = la;
      load_data  = ld;
      #1;
      m_valid = (q.size() > 0) && (q[0].t <= edges);
      m_ready = !fl && !le && (q.size() < RL + 1);
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("req_ready",  32'(req_ready),  32'(m_ready));
      chk("busy",       32'(busy),       32'(q.size() != 0));
      if (m_valid) begin
         chk("resp_instr", resp_instr,        q[0].instr);
         chk("resp_addr",  resp_addr,         q[0].addr);
         chk("resp_fault", 32'(resp_fault),   32'(q[0].fault));
      end
      hs  = m_valid && rr;
      acc = rv && m_ready;
      if (hs) e = q.pop_front();
      if (fl) q.delete();
      if (acc) begin
         e.addr  = ra;
         e.fault = (ra >= DEPTH);
         e.instr = e.fault ? NOP : mmem[ra[7:0]];
         e.t     = edges + 1 + RL;
         q.push_back(e);
      end
      if (le && la < DEPTH) mmem[la[7:0]] = ld;
      @(posedge clock);
      edges++;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic check_reset_values();
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_instr", resp_instr,      32'h0);
      chk("rst_resp_addr",  resp_addr,       32'h0);
      chk("rst_resp_fault", 32'(resp_fault), 32'h0);
      chk("rst_busy",       32'(busy),       32'h0);
      chk("rst_req_ready",  32'(req_ready),  32'h1);
   endtask

   // Asynchronous reset applied between edges; outputs must react at once.
   task automatic mid_reset();
      @(negedge clock);
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      flush      = 1'b0;
      load_en    = 1'b0;
      #1;
      check_reset_values();
      q.delete();
      @(posedge clock);
      edges++;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      flush      = 1'b0;
      load_en    = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      #12;
      check_reset_values();
      @(posedge clock);
      edges++;
      #2;
      reset_n = 1'b1;

      // Program load: whole memory, words 0..3 fixed
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i),
              (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom);
      // Out-of-range load is ignored; request during load is not accepted
      step(1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd300, 32'h0BAD_0BAD);
      idle(1'b1);

      // Latency / throughput: back-to-back fetch of 0..3
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle(1'b1);

      // Back-pressure: consumer stalled, requests held
      for (int i = 0; i < 6; i++) step(1'b1, 32'(10 + i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (6) idle(1'b1);

      // Fault boundary
      step(1'b1, 32'd256,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'd255,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle(1'b1);

      // Flush with three outstanding, then immediate refetch of word 1
      for (int i = 0; i < 3; i++) step(1'b1, 32'(20 + i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'd9, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle(1'b1);

      // Load then fetch on the next cycle
      step(1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
      step(1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle(1'b1);

      // Reset mid-burst; memory must survive, nothing stale may appear
      step(1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'd31, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mid_reset();
      repeat (3) idle(1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle(1'b1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic        rv, rr, fl, le;
         logic [31:0] ra, la;
         rv = ($urandom_range(0, 3) != 0);
         ra = ($urandom_range(0, 15) == 0) ? 32'(256 + $urandom_range(0, 1000))
                                           : 32'($urandom_range(0, 255));
         rr = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 40) == 0);
         le = ($urandom_range(0, 30) == 0);
         la = 32'($urandom_range(0, 270));
         if (n == 1500) mid_reset();
         step(rv, ra, rr, fl, le, la, $urandom);
      end
      repeat (8) idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
